// File: rtl/div_pkg.sv
// Shared definitions for the HI/LO divide controller: op codes, FSM states
// and the LO value written on a divide-by-zero.
package div_pkg;

  typedef enum logic [2:0] {
    OP_NONE = 3'd0,
    OP_DIV  = 3'd1,
    OP_DIVU = 3'd2,
    OP_MTHI = 3'd3,
    OP_MTLO = 3'd4
  } op_e;

  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT,
    HOLD
  } state_e;

  localparam logic [31:0] DIV0_LO = 32'hFFFF_FFFF;

endpackage

// File: rtl/div_hilo_ctrl_sign_fix.sv
// Conditional two's-complement negate. Used both to take operand magnitudes
// and to restore the sign of the divider's quotient/remainder.
module sign_fix (
  input  logic        neg,
  input  logic [31:0] din,
  output logic [31:0] dout
);

  // Negate when requested; mod 2^32, so 0x80000000 maps to itself.
  always_comb begin
    dout = neg ? (~din + 32'd1) : din;
  end

endmodule

// File: rtl/div_hilo_ctrl.sv
// Execute-stage controller for DIV/DIVU/MTHI/MTLO. Drives an external 32-bit
// unsigned iterative divider, sign-corrects its results and owns HI/LO.
module div_hilo_ctrl
  import div_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        op_valid,
  input  logic [2:0]  op,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic        ext_stall,
  input  logic        flush,
  output logic        stall_req,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] div_dividend,
  output logic [31:0] div_divisor,
  output logic        div_start,
  output logic        div_cpu_stall,
  input  logic [31:0] div_q,
  input  logic [31:0] div_r,
  input  logic        div_finish
);

  state_e      state;
  logic        q_neg;
  logic        r_neg;
  logic        is_signed;
  logic        is_divop;
  logic        accept;
  logic [31:0] mag_rs;
  logic [31:0] mag_rt;
  logic [31:0] q_fixed;
  logic [31:0] r_fixed;

  assign is_signed     = (op == OP_DIV);
  assign is_divop      = (op == OP_DIV) || (op == OP_DIVU);
  assign accept        = (state == IDLE) & op_valid & ~ext_stall & ~flush;
  assign div_cpu_stall = ext_stall;

  sign_fix u_mag_rs (
    .neg  (is_signed & rs_data[31]),
    .din  (rs_data),
    .dout (mag_rs)
  );

  sign_fix u_mag_rt (
    .neg  (is_signed & rt_data[31]),
    .din  (rt_data),
    .dout (mag_rt)
  );

  sign_fix u_fix_q (
    .neg  (q_neg),
    .din  (div_q),
    .dout (q_fixed)
  );

  sign_fix u_fix_r (
    .neg  (r_neg),
    .din  (div_r),
    .dout (r_fixed)
  );

  // Stall EX from the cycle a real division is presented until the divider finishes.
  always_comb begin
    stall_req = 1'b0;
    unique case (state)
      IDLE:  stall_req = op_valid & is_divop & (rt_data != '0) & ~flush;
      START: stall_req = 1'b1;
      WAIT:  stall_req = ~div_finish;
      HOLD:  stall_req = 1'b0;
    endcase
  end

  // Control FSM plus HI/LO and latched operand registers.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state        <= IDLE;
      hi           <= '0;
      lo           <= '0;
      div_start    <= 1'b0;
      div_dividend <= '0;
      div_divisor  <= '0;
      q_neg        <= 1'b0;
      r_neg        <= 1'b0;
    end else begin
      div_start <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept) begin
            case (op)
              OP_MTHI: hi <= rs_data;
              OP_MTLO: lo <= rs_data;
              OP_DIV, OP_DIVU: begin
                if (rt_data == '0) begin
                  lo <= DIV0_LO;
                  hi <= rs_data;
                end else begin
                  div_dividend <= mag_rs;
                  div_divisor  <= mag_rt;
                  q_neg        <= is_signed & (rs_data[31] ^ rt_data[31]);
                  r_neg        <= is_signed & rs_data[31];
                  // start is registered so it is high exactly in the START cycle
                  div_start    <= 1'b1;
                  state        <= START;
                end
              end
              default: ;
            endcase
          end
        end
        START: state <= flush ? IDLE : WAIT;
        WAIT: begin
          if (flush) begin
            state <= IDLE;
          end else if (div_finish) begin
            lo    <= q_fixed;
            hi    <= r_fixed;
            // HOLD keeps the still-frozen op from being accepted a second time
            state <= ext_stall ? HOLD : IDLE;
          end
        end
        HOLD: begin
          if (flush || !ext_stall) state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_hilo_ctrl.sv
// Self-checking bench for div_hilo_ctrl with a cycle-level divider model.
module tb_div_hilo_ctrl;
  import div_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic        op_valid;
  logic [2:0]  op;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        ext_stall;
  logic        flush;
  logic        stall_req;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] div_dividend;
  logic [31:0] div_divisor;
  logic        div_start;
  logic        div_cpu_stall;
  logic [31:0] div_q = '0;
  logic [31:0] div_r = '0;
  logic        div_finish = 1'b0;

  int total = 0;
  int bad = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  div_hilo_ctrl dut (
    .clock         (clock),
    .reset         (reset),
    .op_valid      (op_valid),
    .op            (op),
    .rs_data       (rs_data),
    .rt_data       (rt_data),
    .ext_stall     (ext_stall),
    .flush         (flush),
    .stall_req     (stall_req),
    .hi            (hi),
    .lo            (lo),
    .div_dividend  (div_dividend),
    .div_divisor   (div_divisor),
    .div_start     (div_start),
    .div_cpu_stall (div_cpu_stall),
    .div_q         (div_q),
    .div_r         (div_r),
    .div_finish    (div_finish)
  );

  always #5 clock = ~clock;

  // Divider model: 32 unfrozen iteration cycles after start, then a finish pulse.
  logic [5:0] dcnt = '0;
  logic       dbusy = 1'b0;
  always @(posedge clock) begin
    div_finish <= 1'b0;
    if (div_start) begin
      dbusy <= 1'b1;
      dcnt  <= 6'd32;
      div_q <= div_dividend / div_divisor;
      div_r <= div_dividend % div_divisor;
    end else if (dbusy && !div_cpu_stall) begin
      if (dcnt == 6'd1) begin
        dbusy      <= 1'b0;
        div_finish <= 1'b1;
      end
      dcnt <= dcnt - 6'd1;
    end
  end

  // Architectural reference: signed division truncates toward zero, done in 64 bits.
  function automatic void model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    case (o)
      OP_MTHI: m_hi = a;
      OP_MTLO: m_lo = a;
      OP_DIVU, OP_DIV: begin
        if (b == 32'd0) begin
          m_lo = 32'hFFFF_FFFF;
          m_hi = a;
        end else if (o == OP_DIVU) begin
          m_lo = a / b;
          m_hi = a % b;
        end else begin
          sa = longint'($signed(a));
          sb = longint'($signed(b));
          q = sa / sb;
          r = sa % sb;
          m_lo = q[31:0];
          m_hi = r[31:0];
        end
      end
      default: ;
    endcase
  endfunction

  function automatic int exp_stall(input logic [2:0] o, input logic [31:0] b, input int extra);
    if ((o == OP_DIV || o == OP_DIVU) && b != 32'd0) return 34 + extra;
    return 0;
  endfunction

  // Present one op as the pipeline would: hold it until EX may advance.
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input int st_from, input int st_len,
                        output int nstall, output int nstart);
    int c;
    logic adv;
    nstall = 0; nstart = 0; c = 0; adv = 1'b0;
    op_valid = 1'b1; op = o; rs_data = a; rt_data = b;
    while (!adv && c < 200) begin
      ext_stall = (c >= st_from) && (c < st_from + st_len);
      @(negedge clock);
      if (stall_req) nstall++;
      if (div_start) nstart++;
      adv = !stall_req && !ext_stall;
      @(posedge clock); #1;
      c++;
    end
    op_valid = 1'b0; ext_stall = 1'b0; op = OP_NONE;
    total++;
    if (!adv) begin
      bad++;
      $display("FAIL op_timeout: got no advance after %0d cycles, expected advance", c);
    end
  endtask

  task automatic check_hilo(input string name);
    total++;
    if (hi !== m_hi) begin bad++; $display("FAIL %s_hi: got %h expected %h", name, hi, m_hi); end
    total++;
    if (lo !== m_lo) begin bad++; $display("FAIL %s_lo: got %h expected %h", name, lo, m_lo); end
  endtask

  task automatic test_reset;
    reset = 1'b0; op_valid = 1'b0; op = OP_NONE; rs_data = '0; rt_data = '0;
    ext_stall = 1'b0; flush = 1'b0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b1;
    @(negedge clock);
    check_hilo("reset");
    total++;
    if ({div_start, stall_req} !== 2'b00) begin
      bad++; $display("FAIL reset_ctl: got start/stall %b expected 00", {div_start, stall_req});
    end
    total++;
    if ({div_dividend, div_divisor} !== 64'd0) begin
      bad++; $display("FAIL reset_operands: got %h/%h expected 0/0", div_dividend, div_divisor);
    end
    @(posedge clock); #1;
  endtask

  task automatic test_divide(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                             input string name);
    int ns, nst;
    run_op(o, a, b, -1, 0, ns, nst);
    model(o, a, b);
    check_hilo(name);
    total++;
    if (ns != exp_stall(o, b, 0)) begin
      bad++; $display("FAIL %s_stall: got %0d expected %0d", name, ns, exp_stall(o, b, 0));
    end
    total++;
    if (nst != ((exp_stall(o, b, 0) != 0) ? 1 : 0)) begin
      bad++; $display("FAIL %s_starts: got %0d expected %0d", name, nst, (exp_stall(o, b, 0) != 0) ? 1 : 0);
    end
  endtask

  task automatic test_ext_stall;
    int ns, nst, late;
    run_op(OP_DIVU, 32'd1000, 32'd10, 10, 5, ns, nst);
    model(OP_DIVU, 32'd1000, 32'd10);
    check_hilo("stall_mid");
    total++;
    if (ns != 39) begin bad++; $display("FAIL stall_mid_count: got %0d expected 39", ns); end
    // ext_stall held across the finish cycle and one more
    run_op(OP_DIVU, 32'd1000, 32'd10, 34, 2, ns, nst);
    late = 0;
    repeat (4) begin
      @(negedge clock);
      if (div_start) late++;
      @(posedge clock); #1;
    end
    check_hilo("stall_fin");
    total++;
    if (ns != 34) begin bad++; $display("FAIL stall_fin_count: got %0d expected 34", ns); end
    total++;
    if (nst + late != 1) begin bad++; $display("FAIL stall_fin_restart: got %0d starts expected 1", nst + late); end
  endtask

  task automatic test_flush;
    op_valid = 1'b1; op = OP_DIVU; rs_data = 32'd50; rt_data = 32'd3;
    for (int c = 0; c < 12; c++) begin
      flush = (c == 11);
      @(posedge clock); #1;
    end
    flush = 1'b0; op_valid = 1'b0; op = OP_NONE;
    @(negedge clock);
    total++;
    if (stall_req !== 1'b0) begin bad++; $display("FAIL flush_idle: got stall_req %b expected 0", stall_req); end
    repeat (30) @(posedge clock);
    #1;
    check_hilo("flush_keep");
    test_divide(OP_DIVU, 32'd9, 32'd4, "after_flush");
  endtask

  task automatic test_back_to_back;
    int ns, nst;
    run_op(OP_MTHI, 32'h0000_AAAA, 32'd0, -1, 0, ns, nst);
    run_op(OP_MTLO, 32'h0000_5555, 32'd0, -1, 0, ns, nst);
    model(OP_MTHI, 32'h0000_AAAA, 32'd0);
    model(OP_MTLO, 32'h0000_5555, 32'd0);
    check_hilo("b2b");
  endtask

  task automatic test_reset_mid;
    op_valid = 1'b1; op = OP_DIV; rs_data = 32'hFFFF_0000; rt_data = 32'd7;
    for (int c = 0; c < 15; c++) begin
      @(posedge clock); #1;
    end
    op_valid = 1'b0; op = OP_NONE; reset = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1;
    m_hi = '0; m_lo = '0;
    @(negedge clock);
    check_hilo("rst_mid");
    total++;
    if ({div_start, stall_req, div_dividend, div_divisor} !== 66'd0) begin
      bad++; $display("FAIL rst_mid_outs: got start %b stall %b dd %h dv %h expected all 0",
                      div_start, stall_req, div_dividend, div_divisor);
    end
    repeat (30) @(posedge clock);
    @(negedge clock);
    check_hilo("rst_stray");
    total++;
    if (stall_req !== 1'b0) begin bad++; $display("FAIL rst_stray_stall: got %b expected 0", stall_req); end
    @(posedge clock); #1;
  endtask

  task automatic test_random;
    logic [2:0]  o;
    logic [31:0] a, b;
    for (int i = 0; i < 24; i++) begin
      o = 3'($urandom_range(1, 4));
      a = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: b = 32'hFFFF_FFFF;
        2, 3: b = 32'($urandom_range(1, 20));
        default: b = $urandom;
      endcase
      test_divide(o, a, b, "rand");
    end
  endtask

  initial begin
    test_reset;
    test_divide(OP_DIVU, 32'd100, 32'd7, "divu_basic");
    test_divide(OP_DIV, 32'hFFFF_FFF9, 32'd2, "div_neg");
    test_divide(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
    test_divide(OP_DIV, 32'h0000_1234, 32'd0, "div_zero");
    test_ext_stall;
    test_flush;
    test_back_to_back;
    test_random;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/div_hilo_ctrl.md
# div_hilo_ctrl

Execute-stage controller that accepts DIV/DIVU/MTHI/MTLO operations from the pipeline and drives the 32-bit unsigned iterative divider (`start`/`busy`/`finish`/`cpu_stall` handshake). It converts signed operands to magnitudes, sign-corrects the quotient and remainder, and owns the architectural HI/LO registers. It also raises the pipeline stall request while a division is outstanding.

## Interface
Parameters: none (widths fixed at 32).

Ports:
- `clock`  in  1  system clock, all state on rising edge.
- `reset`  in  1  synchronous reset, active-low.
- `op_valid`  in  1  EX-stage op present.
- `op`  in  3  operation code; see Structure.
- `rs_data`  in  32  dividend / MTHI / MTLO source.
- `rt_data`  in  32  divisor.
- `ext_stall`  in  1  pipeline frozen by another source.
- `flush`  in  1  cancel any outstanding division.
- `stall_req`  out  1  hold EX while division is outstanding.
- `hi`  out  32  HI register; MFHI reads it directly.
- `lo`  out  32  LO register; MFLO reads it directly.
- `div_dividend`  out  32  unsigned magnitude to divider.
- `div_divisor`  out  32  unsigned magnitude to divider.
- `div_start`  out  1  one-cycle start pulse.
- `div_cpu_stall`  out  1  equals `ext_stall`; freezes divider iterations.
- `div_q`  in  32  unsigned quotient from divider.
- `div_r`  in  32  unsigned remainder from divider.
- `div_finish`  in  1  one-cycle completion pulse from divider.

## Operation
- Reset (`reset`=0 at edge): state IDLE, `hi`=`lo`=0, `div_start`=0, latched operands and sign flags = 0. `stall_req` is 0 whenever `op_valid`=0.
- `accept` = IDLE & `op_valid` & ~`ext_stall` & ~`flush`.
- **MTHI / MTLO** on `accept`: `hi` or `lo` is set to `rs_data`. No stall.
- **DIV / DIVU** on `accept`:
  - If `rt_data`==0: write `lo`=0xFFFFFFFF and `hi`=`rs_data` in the same edge. No stall. Next state is IDLE.
  - Otherwise:
    - Latch magnitudes. For DIV, use the two's-complement absolute value; |0x80000000| = 0x80000000.
    - Latch `q_neg` = sign(rs) XOR sign(rt), and `r_neg` = sign(rs). Both are 0 for DIVU.
    - Go to START.
- **States:**
  - START: `div_start`=1 for exactly one cycle, independent of `ext_stall`. Always go to WAIT.
  - WAIT: wait for `div_finish`. When it arrives:
    - `lo` = q_neg ? −q : q.
    - `hi` = r_neg ? −r : r.
    - Arithmetic is mod 2^32, so 0x80000000 / −1 gives 0x80000000.
    - Next state is HOLD if `ext_stall`, else IDLE.
  - HOLD: `stall_req`=0 and new ops are ignored, so the retiring op is not reissued. Go to IDLE when `ext_stall`=0.
- `stall_req` = (IDLE & `op_valid` & op∈{DIV,DIVU} & `rt_data`≠0 & ~`flush`) | START | (WAIT & ~`div_finish`).
- `flush` in START/WAIT/HOLD: go to IDLE next edge. HI/LO unchanged. A later `div_finish` seen in IDLE is ignored. A subsequent start re-arms the divider, because the divider's start overrides busy.
- Reset mid-division: same as reset. A stray `div_finish` afterwards is ignored.

## Timing
- DIV/DIVU accepted in cycle T:
  - T+1: START.
  - T+2..T+33: divider iterations.
  - T+34: `div_finish`.
  - HI/LO update at the end of T+34.
- `stall_req` is high for cycles T..T+33 (34 cycles) with no `ext_stall`. Each `ext_stall` cycle during T+2..T+33 adds one cycle.
- MTHI/MTLO/div-by-zero: HI/LO visible one cycle after accept.

## Structure
- Package `div_pkg`:
  - Op codes: OP_NONE=0, OP_DIV=1, OP_DIVU=2, OP_MTHI=3, OP_MTLO=4.
  - State enum: IDLE, START, WAIT, HOLD.
  - Constant DIV0_LO=32'hFFFFFFFF.
- One sub-module, `sign_fix`: combinational conditional two's-complement negate, used for operand magnitudes and result correction. The divider is instantiated outside this block.

## Test plan
- DIVU rs=100, rt=7 → `stall_req` high 34 cycles; `lo`=14, `hi`=2.
- DIV rs=−7 (0xFFFFFFF9), rt=2 → `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF → `lo`=0x80000000, `hi`=0.
- DIV rs=0x1234, rt=0 → no stall, no `div_start`; `lo`=0xFFFFFFFF, `hi`=0x1234.
- DIVU 1000/10 with `ext_stall` high 5 cycles mid-WAIT → 39 stall cycles, `lo`=100, `hi`=0. `ext_stall` high in the finish cycle → HOLD, no second `div_start`.
- `flush` at WAIT cycle 10 → IDLE next cycle, HI/LO unchanged, late `div_finish` ignored. A following DIVU 9/4 gives `lo`=2, `hi`=1.
- MTHI 0xAAAA then MTLO 0x5555 back-to-back → `hi`=0xAAAA, `lo`=0x5555. `reset`=0 mid-division → all outputs 0, IDLE.
